bcd_dec_hold: RTL and testbench
===============================

BCD_DEC_HOLD -- requirements
Module: bcd_dec_hold

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: number of cycles a decoded one-hot code is driven (legal 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 1: number of all-zero cycles after each hold, before the next accept (legal 0..255).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port bcd_in  input  4: BCD code to decode.
REQ-006 SHALL have port gs_in  input  1: group-select/valid strobe qualifying bcd_in.
REQ-007 SHALL have port ready  output  1: block can accept a code this cycle.
REQ-008 SHALL have port D  output  10: registered one-hot decimal output; D[k]=1 means digit k.
REQ-009 SHALL have port d_valid  output  1: D is carrying a decoded digit.
REQ-010 SHALL have port err  output  1: illegal code (bcd_in > 9) was accepted.

Function
REQ-011 SHALL implement FSM states IDLE, HOLD, GAP.
REQ-012 SHALL drive ready=1 only in IDLE; a transfer occurs on a cycle with gs_in=1 and ready=1.
REQ-013 SHALL, on a transfer with bcd_in<=9, load D=1<<bcd_in, set d_valid=1 and enter HOLD on the next edge (latency 1 cycle).
REQ-014 SHALL keep D and d_valid stable for exactly HOLD_CYCLES cycles, independent of bcd_in/gs_in.
REQ-015 SHALL, after HOLD, clear D to 0 and d_valid to 0, then spend GAP_CYCLES cycles in GAP; with GAP_CYCLES=0 it SHALL return directly to IDLE.
REQ-016 SHALL ignore gs_in outside IDLE (no queuing, no err).
REQ-017 SHALL, on a transfer with bcd_in in 10..15, keep D=0 and d_valid=0, assert err, and remain in IDLE.
REQ-018 SHALL use an 8-bit down-counter shared by HOLD and GAP; wrap-around is forbidden; it reloads on each state entry.
REQ-019 SHALL never assert more than one bit of D; D=0 whenever d_valid=0.
REQ-020 SHALL accept back-to-back codes with a spacing of exactly 1+HOLD_CYCLES+GAP_CYCLES cycles between transfers.

Reset
REQ-021 SHALL, while reset=1, force state IDLE, D=0, d_valid=0, err=0, counter=0, ready=0; ready rises the first cycle after reset deasserts.
REQ-022 SHALL abort a HOLD or GAP in progress when reset asserts mid-operation; the next edge shows all outputs at reset values.
REQ-023 SHALL give reset priority over a simultaneous transfer; that transfer is discarded.

Configuration
REQ-024 SHALL support macro BCD_DEC_ERR_STICKY_EN.
REQ-025 SHALL, with BCD_DEC_ERR_STICKY_EN defined, hold err at 1 from the first illegal transfer until reset.
REQ-026 SHALL, without BCD_DEC_ERR_STICKY_EN, assert err for exactly one cycle per illegal transfer.

Structure
REQ-027 SHALL define the following in shared package bcd_dec_pkg:
- state enum (IDLE/HOLD/GAP)
- BCD_MAX=9
- DEC_W=10
- CNT_W=8
REQ-028 SHALL place the combinational code-to-one-hot mapping in sub-module bcd_onehot (4-bit in, 10-bit out, legal flag).

Verification
REQ-029 SHALL have a bench cover: reset then gs_in=1, bcd_in=4 -> next cycle D=10'b0000010000, d_valid=1 for 4 cycles, then D=0 for 1 GAP cycle, then ready=1.
REQ-030 SHALL have a bench cover: sweep bcd_in 0..9, each held with gs_in until ready -> D=1<<i each time, exactly one hot bit, err never set.
REQ-031 SHALL have a bench cover: bcd_in=12 with gs_in=1 -> D=0, d_valid=0, err=1 one cycle (sticky if BCD_DEC_ERR_STICKY_EN), ready stays 1.
REQ-032 SHALL have a bench cover: gs_in=1, bcd_in=7 accepted, then bcd_in=2 presented during HOLD -> D remains 10'b0010000000; 2 is accepted only once ready returns.
REQ-033 SHALL have a bench cover: reset asserted at the 2nd HOLD cycle of digit 9 -> next edge D=0, d_valid=0, err=0, ready=0; ready=1 one cycle after release.
REQ-034 SHALL have a bench cover: GAP_CYCLES=0, HOLD_CYCLES=1 with continuous gs_in -> transfers every 2 cycles, D alternating code/0.

Source files
------------

// File: rtl/bcd_dec_pkg.sv
// Shared types and constants for the BCD one-hot decoder with hold/gap timing.
package bcd_dec_pkg;

    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam int unsigned DEC_W   = 10;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_onehot.sv
// Combinational BCD to one-hot decimal mapping; illegal codes (10..15) give all-zero output.
module bcd_onehot
    import bcd_dec_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [DEC_W-1:0] dec,
    output logic             legal
);

    always_comb begin
        legal = (bcd <= BCD_MAX);
        dec   = legal ? (DEC_W'(1) << bcd) : '0;
    end

endmodule

// File: rtl/bcd_dec_hold.sv
// BCD decoder that holds each decoded digit for HOLD_CYCLES, then idles GAP_CYCLES.
// Optional macro BCD_DEC_ERR_STICKY_EN: err stays set from first illegal code until reset.
module bcd_dec_hold
    import bcd_dec_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       bcd_in,
    input  logic             gs_in,
    output logic             ready,
    output logic [DEC_W-1:0] D,
    output logic             d_valid,
    output logic             err
);

    // Counter reloads with (cycles - 1) so it reaches zero on the last cycle of the phase.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEC_W-1:0] d_q, d_d;
    logic             d_valid_q, d_valid_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;

    logic [DEC_W-1:0] dec;
    logic             legal;
    logic             xfer;

    bcd_onehot u_onehot (
        .bcd   (bcd_in),
        .dec   (dec),
        .legal (legal)
    );

    assign xfer = gs_in & ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        d_valid_d = d_valid_q;
`ifdef BCD_DEC_ERR_STICKY_EN
        err_d     = err_q;
`else
        err_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (legal) begin
                        state_d   = HOLD;
                        cnt_d     = HOLD_LOAD;
                        d_d       = dec;
                        d_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    d_d       = '0;
                    d_valid_d = 1'b0;
                    cnt_d     = GAP_LOAD;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                d_d       = '0;
                d_valid_d = 1'b0;
            end
        endcase
        // Registered so ready stays low for the first cycle after reset releases.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            d_q       <= '0;
            d_valid_q <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            d_valid_q <= d_valid_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    assign D       = d_q;
    assign d_valid = d_valid_q;
    assign err     = err_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_bcd_dec_hold.sv
// Directed bench for bcd_dec_hold: default instance (4/1) plus a 1/0 instance for back-to-back.
module tb_bcd_dec_hold;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] bcd_in, bcd2;
    logic       gs_in, gs2;
    logic       ready, d_valid, err;
    logic       ready2, d_valid2, err2;
    logic [9:0] D, D2;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];

`ifdef BCD_DEC_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    always #5 clk = ~clk;

    bcd_dec_hold dut (
        .clk     (clk),
        .reset   (reset),
        .bcd_in  (bcd_in),
        .gs_in   (gs_in),
        .ready   (ready),
        .D       (D),
        .d_valid (d_valid),
        .err     (err)
    );

    bcd_dec_hold #(
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (0)
    ) dut2 (
        .clk     (clk),
        .reset   (reset),
        .bcd_in  (bcd2),
        .gs_in   (gs2),
        .ready   (ready2),
        .D       (D2),
        .d_valid (d_valid2),
        .err     (err2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] exp_dec(input int v);
        return (v <= 9) ? (10'd1 << v) : 10'd0;
    endfunction

    function automatic logic [9:0] pop_exp();
        if (exp_q.size() == 0) return 10'bx;
        return exp_q.pop_front();
    endfunction

    task automatic wait_ready;
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("wait_ready", 10'(ready), 10'd1);
    endtask

    // Present a code in IDLE for exactly one transfer; returns in the first HOLD cycle.
    task automatic xfer(input int v);
        wait_ready();
        gs_in  = 1'b1;
        bcd_in = 4'(v);
        exp_q.push_back(exp_dec(v));
        tick();
        gs_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] e;
        reset  = 1'b1;
        gs_in  = 1'b0;
        bcd_in = 4'd0;
        gs2    = 1'b0;
        bcd2   = 4'd0;
        tick();
        tick();
        chk("rst_D", D, 10'd0);
        chk("rst_dvalid", 10'(d_valid), 10'd0);
        chk("rst_err", 10'(err), 10'd0);
        chk("rst_ready", 10'(ready), 10'd0);
        reset = 1'b0;
        chk("rst_ready_release", 10'(ready), 10'd0);
        tick();
        chk("ready_after_rst", 10'(ready), 10'd1);

        // Digit 4: four HOLD cycles, one GAP cycle, then ready.
        xfer(4);
        e = pop_exp();
        for (int i = 0; i < 4; i++) begin
            chk("d4_hold_D", D, e);
            chk("d4_hold_dv", 10'(d_valid), 10'd1);
            chk("d4_hold_ready", 10'(ready), 10'd0);
            tick();
        end
        chk("d4_gap_D", D, 10'd0);
        chk("d4_gap_dv", 10'(d_valid), 10'd0);
        chk("d4_gap_ready", 10'(ready), 10'd0);
        tick();
        chk("d4_idle_ready", 10'(ready), 10'd1);

        // Sweep all legal digits.
        for (int i = 0; i <= 9; i++) begin
            xfer(i);
            e = pop_exp();
            chk("sweep_D", D, e);
            chk("sweep_onehot", 10'($countones(D)), 10'd1);
            chk("sweep_err", 10'(err), 10'd0);
        end

        // Digit 7 accepted, 2 presented during HOLD must wait.
        xfer(7);
        e = pop_exp();
        chk("hold7_D", D, e);
        gs_in  = 1'b1;
        bcd_in = 4'd2;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("hold7_stable", D, 10'b0010000000);
        end
        tick();
        chk("hold7_gap_D", D, 10'd0);
        chk("hold7_gap_ready", 10'(ready), 10'd0);
        tick();
        chk("hold7_idle_ready", 10'(ready), 10'd1);
        exp_q.push_back(exp_dec(2));
        tick();
        gs_in = 1'b0;
        e = pop_exp();
        chk("late2_D", D, e);
        chk("late2_err", 10'(err), 10'd0);

        // Illegal code 12.
        wait_ready();
        gs_in  = 1'b1;
        bcd_in = 4'd12;
        tick();
        gs_in = 1'b0;
        chk("ill_D", D, 10'd0);
        chk("ill_dv", 10'(d_valid), 10'd0);
        chk("ill_err", 10'(err), 10'd1);
        chk("ill_ready", 10'(ready), 10'd1);
        tick();
        chk("ill_err_next", 10'(err), 10'(STICKY));
        chk("ill_ready_next", 10'(ready), 10'd1);

        // Reset in second HOLD cycle of digit 9, with a competing strobe.
        xfer(9);
        e = pop_exp();
        chk("d9_D", D, e);
        tick();
        reset  = 1'b1;
        gs_in  = 1'b1;
        bcd_in = 4'd3;
        tick();
        chk("abort_D", D, 10'd0);
        chk("abort_dv", 10'(d_valid), 10'd0);
        chk("abort_err", 10'(err), 10'd0);
        chk("abort_ready", 10'(ready), 10'd0);
        reset = 1'b0;
        gs_in = 1'b0;
        chk("abort_ready_release", 10'(ready), 10'd0);
        tick();
        chk("abort_ready_after", 10'(ready), 10'd1);

        // Reset wins over a transfer presented while ready.
        gs_in  = 1'b1;
        bcd_in = 4'd5;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        gs_in = 1'b0;
        chk("prio_dv", 10'(d_valid), 10'd0);
        chk("prio_D", D, 10'd0);
        tick();
        chk("prio_ready", 10'(ready), 10'd1);
        chk("prio_dv_after", 10'(d_valid), 10'd0);

        // HOLD=1, GAP=0 instance with continuous strobe: transfer every 2 cycles.
        gs2 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bcd2 = 4'(k + 3);
            chk("b2b_ready", 10'(ready2), 10'd1);
            exp_q.push_back(exp_dec(k + 3));
            tick();
            e = pop_exp();
            chk("b2b_D", D2, e);
            chk("b2b_dv", 10'(d_valid2), 10'd1);
            chk("b2b_busy", 10'(ready2), 10'd0);
            tick();
            chk("b2b_zero", D2, 10'd0);
            chk("b2b_dv0", 10'(d_valid2), 10'd0);
        end
        gs2 = 1'b0;
        chk("scoreboard_empty", 10'(exp_q.size()), 10'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
